// File: rtl/water_tank_controller.sv
// Tank emptying sequencer: round-robin sprinkler/dripper grants draining a 3-bit level,
// with forced or requested refill cycles, all paced by an external tick enable.
module water_tank_controller #(
  parameter int SPRINKLER_TICKS = 2,
  parameter int DRIPPER_TICKS   = 4,
  parameter int REFILL_TICKS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       sprinkler_req,
  input  logic       dripper_req,
  input  logic       refill_req,
  output logic [2:0] water_level,
  output logic       sprinkler_on,
  output logic       dripper_on,
  output logic       refill_on,
  output logic       tank_full,
  output logic       tank_empty
);

  typedef enum logic [1:0] {IDLE, SPRINKLE, DRIP, REFILL} state_t;

  localparam logic [3:0] SPR_LAST = 4'(SPRINKLER_TICKS - 1);
  localparam logic [3:0] DRP_LAST = 4'(DRIPPER_TICKS - 1);
  localparam logic [3:0] REF_LAST = 4'(REFILL_TICKS - 1);
  localparam logic GRANT_SPR = 1'b0;
  localparam logic GRANT_DRP = 1'b1;

  state_t     state, state_n;
  logic [3:0] count, count_n;
  logic [2:0] level_n;
  logic       last_grant, last_grant_n;
  logic       own_req;
  logic [3:0] drain_last;

  assign own_req    = (state == DRIP) ? dripper_req : sprinkler_req;
  assign drain_last = (state == DRIP) ? DRP_LAST : SPR_LAST;

  always_comb begin
    state_n      = state;
    count_n      = count;
    level_n      = water_level;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (water_level == 3'd7) begin
          state_n = REFILL;
        end else if (sprinkler_req && dripper_req) begin
          state_n = (last_grant == GRANT_DRP) ? SPRINKLE : DRIP;
        end else if (sprinkler_req) begin
          state_n = SPRINKLE;
        end else if (dripper_req) begin
          state_n = DRIP;
        end else if (refill_req && water_level != 3'd0) begin
          state_n = REFILL;
        end
        if (state_n == SPRINKLE) last_grant_n = GRANT_SPR;
        if (state_n == DRIP)     last_grant_n = GRANT_DRP;
      end
      SPRINKLE, DRIP: begin
        // a dropped request wins over a coincident tick
        if (!own_req) begin
          state_n = IDLE;
        end else if (tick) begin
          if (count == drain_last) begin
            count_n = 4'd0;
            if (water_level != 3'd7) level_n = water_level + 3'd1;
            if (water_level >= 3'd6) state_n = REFILL;
          end else begin
            count_n = count + 4'd1;
          end
        end
      end
      REFILL: begin
        if (water_level == 3'd0) begin
          state_n = IDLE;
        end else if (tick) begin
          if (count == REF_LAST) begin
            count_n = 4'd0;
            level_n = water_level - 3'd1;
            if (water_level == 3'd1) state_n = IDLE;
          end else begin
            count_n = count + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) count_n = 4'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      last_grant   <= GRANT_DRP;
      water_level  <= 3'd0;
      sprinkler_on <= 1'b0;
      dripper_on   <= 1'b0;
      refill_on    <= 1'b0;
      tank_full    <= 1'b1;
      tank_empty   <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      last_grant   <= last_grant_n;
      water_level  <= level_n;
      sprinkler_on <= (state_n == SPRINKLE);
      dripper_on   <= (state_n == DRIP);
      refill_on    <= (state_n == REFILL);
      tank_full    <= (level_n == 3'd0);
      tank_empty   <= (level_n == 3'd7);
    end
  end

endmodule
